// File: rtl/ets_alert_ctrl.sv
// ETS alert controller: counts accepted anomalies per cycle window, raises sticky alert + irq.
// Optional anomaly log FIFO enabled by defining ETS_ALERT_LOG_EN.
module ets_alert_ctrl #(
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             result_valid,
  input  logic             anomaly_detected,
  input  logic             too_slow,
  input  logic             too_fast,
  input  logic [31:0]      timing_delta,
  input  logic [31:0]      inst_pc,
  input  logic             monitor_enable,
  input  logic [15:0]      window_len,
  input  logic [CNT_W-1:0] threshold,
  input  logic             alert_clear,
  output logic             alert,
  output logic             irq,
  output logic [31:0]      anomaly_total,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [47:0]      log_data,
  output logic [CNT_W-1:0] log_overflow_cnt
);

  typedef enum logic [1:0] {IDLE, WINDOW, ALERT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      elapsed_q, elapsed_d;
  logic             alert_q, alert_d;
  logic             irq_q, irq_d;
  logic [31:0]      total_q, total_d;

  logic             accepted;
  logic [15:0]      len_eff;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] count_inc;

  assign accepted  = result_valid & anomaly_detected & monitor_enable;
  assign len_eff   = (window_len == 16'd0) ? 16'd1 : window_len;
  assign thr_eff   = (threshold == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : threshold;
  assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

  // Window age is tracked as elapsed cycles so a live window_len change applies at once.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    elapsed_d = elapsed_q;
    case (state_q)
      IDLE: begin
        if (accepted) begin
          count_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          elapsed_d = 16'd1;
          state_d   = (thr_eff == {{(CNT_W-1){1'b0}}, 1'b1}) ? ALERT : WINDOW;
        end
      end
      WINDOW: begin
        if (!monitor_enable) begin
          state_d   = IDLE;
          count_d   = '0;
          elapsed_d = '0;
        end else begin
          if (accepted) count_d = count_inc;
          if (accepted && (count_inc >= thr_eff)) begin
            state_d = ALERT;
          end else if (elapsed_q >= len_eff - 16'd1) begin
            state_d   = IDLE;
            count_d   = '0;
            elapsed_d = '0;
          end else begin
            elapsed_d = elapsed_q + 16'd1;
          end
        end
      end
      ALERT: begin
        if (alert_clear) begin
          state_d   = IDLE;
          count_d   = '0;
          elapsed_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        count_d   = '0;
        elapsed_d = '0;
      end
    endcase
  end

  always_comb begin
    alert_d = (state_d == ALERT);
    irq_d   = (state_d == ALERT) && (state_q != ALERT);
    total_d = (accepted && (total_q != 32'hFFFF_FFFF)) ? total_q + 32'd1 : total_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      elapsed_q <= '0;
      alert_q   <= 1'b0;
      irq_q     <= 1'b0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      elapsed_q <= elapsed_d;
      alert_q   <= alert_d;
      irq_q     <= irq_d;
      total_q   <= total_d;
    end
  end

  assign alert         = alert_q;
  assign irq           = irq_q;
  assign anomaly_total = total_q;

`ifdef ETS_ALERT_LOG_EN
  localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

  logic [47:0]      mem_q [LOG_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   fill_q, fill_d, fill_after_pop;
  logic [47:0]      log_data_q, log_data_d;
  logic             log_valid_q, log_valid_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic [13:0]      delta_sat;
  logic [47:0]      rec;
  logic             pop, full, push_ok;

  always_comb begin
    if ($signed(timing_delta) > 32'sd8191)       delta_sat = 14'h1FFF;
    else if ($signed(timing_delta) < -32'sd8192) delta_sat = 14'h2000;
    else                                         delta_sat = timing_delta[13:0];
  end

  // The registered head is refreshed from the post-update FIFO, so it holds once the FIFO drains.
  always_comb begin
    rec            = {inst_pc, too_slow, too_fast, delta_sat};
    pop            = (fill_q != '0) & log_ready;
    full           = (fill_q == (PTR_W+1)'(LOG_DEPTH));
    push_ok        = accepted & (~full | pop);
    fill_after_pop = fill_q - (PTR_W+1)'(pop);
    fill_d         = fill_after_pop + (PTR_W+1)'(push_ok);
    wr_ptr_d       = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
    ovf_d          = (accepted && full && !pop && (ovf_q != '1)) ? ovf_q + 1'b1 : ovf_q;
    log_valid_d    = (fill_d != '0);
    log_data_d     = log_data_q;
    if (fill_d != '0) begin
      log_data_d = (fill_after_pop == '0) ? rec : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      log_data_q  <= '0;
      log_valid_q <= 1'b0;
      ovf_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      log_data_q  <= log_data_d;
      log_valid_q <= log_valid_d;
      ovf_q       <= ovf_d;
    end
  end

  assign log_valid        = log_valid_q;
  assign log_data         = log_data_q;
  assign log_overflow_cnt = ovf_q;
`else
  localparam int unused_log_depth = LOG_DEPTH;
  logic unused_log_inputs;

  assign unused_log_inputs = ^{log_ready, too_slow, too_fast, timing_delta, inst_pc};
  assign log_valid         = 1'b0;
  assign log_data          = '0;
  assign log_overflow_cnt  = '0;
`endif

endmodule
